// File: rtl/loader_pkg.sv
// loader_pkg: shared types and field widths for the UART instruction-memory loader.
package loader_pkg;
  typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, PAYLOAD, CHECK, RUN} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int LEN_W = 16;
  localparam int SUM_W = 8;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver emitting a one-cycle byte_valid or frame_err pulse per frame.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] data
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  rx_state_t state;
  logic rx_m, rx_s, rx_q;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  // rx_m/rx_s form the synchronizer; rx_q only remembers the previous level for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      {rx_m, rx_s, rx_q} <= 3'b111;
      state <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_q && !rx_s) state <= RX_START;
        end
        RX_START: if (cnt == CW'(CLKS_PER_BIT / 2)) begin
          cnt <= '0;
          idx <= '0;
          state <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt <= '0;
          data <= {rx_s, data[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= RX_STOP;
        end
        RX_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt <= '0;
          byte_valid <= rx_s;
          frame_err <= !rx_s;
          state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed, checksummed image over UART and writes it byte-wise into instruction memory.
module imem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 32,
  parameter int IMEM_DEPTH   = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemData,
  output logic [WIDTH-1:0] insMemAddr,
  output logic             cpuReset,
  output logic             done,
  output logic             error
);
  state_t state;
  logic byte_valid, frame_err;
  logic [7:0] rx_byte;
  logic [LEN_W-1:0] len, addr, len_full;
  logic [SUM_W-1:0] sum;
  assign len_full = {rx_byte, len[7:0]};
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .byte_valid(byte_valid),
    .frame_err(frame_err),
    .data(rx_byte)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SYNC;
      len <= '0;
      addr <= '0;
      sum <= '0;
      insMemEn <= 1'b0;
      insMemData <= '0;
      insMemAddr <= '0;
      cpuReset <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      insMemEn <= 1'b0;
      if (frame_err && state != SYNC && state != RUN) begin
        error <= 1'b1;
        state <= SYNC;
      end else if (byte_valid) begin
        case (state)
          SYNC, RUN: if (rx_byte == SYNC_BYTE) begin
            state <= LEN_LO;
            error <= 1'b0;
            done <= 1'b0;
            cpuReset <= 1'b1;
            addr <= '0;
            sum <= '0;
          end
          LEN_LO: begin
            len[7:0] <= rx_byte;
            state <= LEN_HI;
          end
          LEN_HI: begin
            len <= len_full;
            if (len_full == '0 || 32'(len_full) > IMEM_DEPTH) begin
              error <= 1'b1;
              state <= SYNC;
            end else state <= PAYLOAD;
          end
          PAYLOAD: begin
            insMemEn <= 1'b1;
            insMemData <= WIDTH'(rx_byte);
            insMemAddr <= WIDTH'(addr);
            addr <= addr + 1'b1;
            sum <= sum + rx_byte;
            if (addr + 1'b1 == len) state <= CHECK;
          end
          CHECK: if (rx_byte == sum) begin
            done <= 1'b1;
            cpuReset <= 1'b0;
            state <= RUN;
          end else begin
            error <= 1'b1;
            state <= SYNC;
          end
          default: state <= SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, hand-written corner sequences and random images against a byte-level expectation.
module tb_imem_loader;
  localparam int CPB = 4;
  localparam int W = 32;
  localparam int DEPTH = 4096;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1;
  logic insMemEn, cpuReset, done, error;
  logic [W-1:0] insMemData, insMemAddr;
  int compared = 0, mismatched = 0;
  logic [W-1:0] wr_addr_q[$], wr_data_q[$];
  typedef struct {
    logic [0:7][7:0] b;
    int n;
    int nwr;
    logic d, e, c;
  } vec_t;
  vec_t vecs[9];

  imem_loader #(.CLKS_PER_BIT(CPB), .WIDTH(W), .IMEM_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .insMemEn(insMemEn),
    .insMemData(insMemData),
    .insMemAddr(insMemAddr),
    .cpuReset(cpuReset),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (insMemEn) begin
    wr_addr_q.push_back(insMemAddr);
    wr_data_q.push_back(insMemData);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
  endtask

  task automatic expect_image(input string tag, input logic [7:0] pl[$], input logic d, input logic e, input logic c);
    check($sformatf("%s_nwr", tag), W'(wr_addr_q.size()), W'(pl.size()));
    for (int i = 0; i < pl.size(); i++) if (i < wr_addr_q.size()) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], W'(i));
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], W'(pl[i]));
    end
    check($sformatf("%s_done", tag), W'(done), W'(d));
    check($sformatf("%s_error", tag), W'(error), W'(e));
    check($sformatf("%s_cpuReset", tag), W'(cpuReset), W'(c));
    check($sformatf("%s_en_idle", tag), W'(insMemEn), 0);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s_cpuReset", tag), W'(cpuReset), 1);
    check($sformatf("%s_done", tag), W'(done), 0);
    check($sformatf("%s_error", tag), W'(error), 0);
    check($sformatf("%s_en", tag), W'(insMemEn), 0);
    check($sformatf("%s_addr", tag), insMemAddr, 0);
    check($sformatf("%s_data", tag), insMemData, 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] s;
    int n;
    bit good, seen;
    vecs[0] = '{b: {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, n: 8, nwr: 4, d: 1, e: 0, c: 0};
    vecs[1] = '{b: {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14}, n: 8, nwr: 4, d: 0, e: 1, c: 1};
    vecs[2] = '{b: {8'hA5, 8'h00, 8'h00, 40'h0}, n: 3, nwr: 0, d: 0, e: 1, c: 1};
    vecs[3] = '{b: {8'hA5, 8'h01, 8'h10, 40'h0}, n: 3, nwr: 0, d: 0, e: 1, c: 1};
    vecs[4] = '{b: {8'h13, 8'h13, 48'h0}, n: 2, nwr: 0, d: 0, e: 1, c: 1};
    vecs[5] = '{b: {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, n: 8, nwr: 4, d: 1, e: 0, c: 0};
    vecs[6] = '{b: {8'h00, 8'hFF, 8'h12, 40'h0}, n: 3, nwr: 0, d: 1, e: 0, c: 0};
    vecs[7] = '{b: {8'hA5, 8'h02, 8'h00, 8'h80, 8'h90, 8'h10, 16'h0}, n: 6, nwr: 2, d: 1, e: 0, c: 0};
    vecs[8] = '{b: {8'hA5, 8'h03, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h0}, n: 7, nwr: 3, d: 0, e: 1, c: 1};

    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int v = 0; v < 9; v++) begin
      // vectors 4 and 6 use their bytes as stray traffic: prefix shifted by 0 when sending
      pl = {};
      for (int j = 0; j < vecs[v].nwr; j++) pl.push_back(vecs[v].b[3 + j]);
      for (int j = 0; j < vecs[v].n; j++) send_byte(vecs[v].b[j]);
      expect_image($sformatf("vec%0d", v), pl, vecs[v].d, vecs[v].e, vecs[v].c);
    end

    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h13);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h13);
    expect_image("frame_err", '{8'h13}, 0, 1, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h42); send_byte(8'h42);
    expect_image("after_ferr", '{8'h42}, 1, 0, 0);

    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    @(negedge clock);
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    expect_image("glitch", '{8'h11, 8'h22}, 1, 0, 0);

    seen = 0;
    fork
      send_byte(8'hA5);
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clock);
        if (cpuReset) begin
          seen = 1;
          check("restart_done", W'(done), 0);
        end
      end
    join
    check("restart_seen", W'(seen), 1);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("mid_reset");
    reset = 1'b0;
    repeat (5) @(negedge clock);
    expect_image("mid_reset_img", '{8'h13, 8'h00}, 0, 0, 1);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 12);
      good = 1'($urandom_range(0, 1));
      pl = {};
      s = 8'h00;
      for (int j = 0; j < n; j++) begin
        pl.push_back(8'($urandom));
        s = s + pl[j];
      end
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 127)));
      send_byte(8'hA5);
      send_byte(8'(n));
      send_byte(8'h00);
      for (int j = 0; j < n; j++) send_byte(pl[j]);
      send_byte(good ? s : s + 8'($urandom_range(1, 255)));
      expect_image($sformatf("rand%0d", r), pl, good, !good, !good);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter WIDTH, default 32, address/data port width.
REQ-003 SHALL have parameter IMEM_DEPTH, default 4096, instruction-memory size in bytes.
REQ-004 clock  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 insMemEn  output  1  one-cycle byte-write strobe to the core's instruction memory.
REQ-008 insMemData  output  WIDTH  payload byte in [7:0]; upper bits SHALL be zero.
REQ-009 insMemAddr  output  WIDTH  byte address of the current write.
REQ-010 cpuReset  output  1  holds the core in reset while no valid image is loaded.
REQ-011 done  output  1  valid image loaded; core running.
REQ-012 error  output  1  sticky load failure flag.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 RX: a falling edge in idle starts a frame; the start bit SHALL be re-checked low at CLKS_PER_BIT/2 or the frame is abandoned.
REQ-015 RX: each data bit and the stop bit SHALL be sampled every CLKS_PER_BIT cycles after the start-bit midpoint.
REQ-016 RX: a stop bit of 1 SHALL produce a one-cycle byte_valid pulse carrying the byte; a stop bit of 0 SHALL produce a one-cycle frame_err pulse and no byte.
REQ-017 Image format: sync byte 0xA5, then length N (2 bytes, little-endian), then N payload bytes, then 1 checksum byte equal to the sum of the payload bytes mod 256.
REQ-018 FSM states SHALL be SYNC, LEN_LO, LEN_HI, PAYLOAD, CHECK, RUN.
REQ-019 SYNC: 0xA5 -> LEN_LO, clearing error and done, setting cpuReset=1, addr=0, sum=0; any other byte SHALL be ignored.
REQ-020 LEN_HI: N=0 or N>IMEM_DEPTH SHALL set error and return to SYNC; otherwise -> PAYLOAD.
REQ-021 PAYLOAD: each byte SHALL assert insMemEn for exactly one cycle, the cycle after byte_valid, with insMemData=byte and insMemAddr=current addr.
REQ-022 PAYLOAD: addr SHALL increment by 1 and sum SHALL accumulate (8-bit wrap) after each write; after the Nth byte -> CHECK.
REQ-023 CHECK: a byte equal to sum SHALL set done=1 and cpuReset=0 on the next cycle -> RUN; a mismatch SHALL set error=1 and keep cpuReset=1 -> SYNC.
REQ-024 RUN: a received 0xA5 SHALL restart loading exactly as in SYNC (cpuReset=1 next cycle, done=0).
REQ-025 A frame_err in any state except SYNC and RUN SHALL set error and return to SYNC; in SYNC or RUN it SHALL be ignored.
REQ-026 insMemEn SHALL never be asserted outside PAYLOAD; insMemAddr SHALL stay below IMEM_DEPTH.

Reset
REQ-027 While reset is high: FSM=SYNC, RX idle, cpuReset=1, done=0, error=0, insMemEn=0, insMemAddr=0, insMemData=0, sum=0.
REQ-028 A reset mid-image SHALL abandon the load; previously written bytes SHALL remain in memory and be overwritten by the next load.

Structure
REQ-029 Package loader_pkg SHALL hold the FSM state enum, SYNC_BYTE=8'hA5 and the length/checksum field widths.
REQ-030 UART reception SHALL be a sub-module uart_rx (synchronizer, bit counter, baud counter, byte_valid/frame_err outputs); the top level SHALL contain the framing FSM and the memory-write logic.

Verification (CLKS_PER_BIT=4)
REQ-031 Send A5 04 00 13 00 00 00 13 -> 4 insMemEn pulses at addresses 0..3 with data 13,00,00,00; then done=1 and cpuReset=0.
REQ-032 Same image with checksum 14 -> error=1, cpuReset stays 1, done=0; a following valid image clears error and loads.
REQ-033 Send length 00 00, then length 01 10 (4097) -> error=1, no insMemEn, FSM in SYNC.
REQ-034 Byte with stop bit 0 during PAYLOAD -> error=1, return to SYNC; a 3-cycle rx glitch low in idle -> no byte_valid.
REQ-035 In RUN, send A5 -> cpuReset=1 and done=0 next cycle; assert reset mid-payload -> all outputs at reset values.
